// File: rtl/sr_latch_if.sv
// Bundle for one bank of clocked SR bits: the set/clear requests in,
// the stored state and the forbidden-input flag out.
interface sr_latch_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] R;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Q_bar;
   logic [WIDTH-1:0] illegal;

   modport master (
      output S,
      output R,
      input  Q,
      input  Q_bar,
      input  illegal
   );

   modport slave (
      input  S,
      input  R,
      output Q,
      output Q_bar,
      output illegal
   );
endinterface

// File: rtl/sr_latch.sv
// Registered SR storage bank: each bit is set/cleared on the clock edge.
// Q_bar comes from the same flop as Q, and S=R=1 is reported one cycle later.
module sr_latch #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
   parameter logic [1:0]       BOTH_POLICY = 2'd0
) (
   input  logic        clk,
   input  logic        rst,
   sr_latch_if.slave   bus
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] illegal_r;
   logic [WIDTH-1:0] q_next_s;

   // Per-bit next state from the sampled set/clear request pair
   always_comb begin
      q_next_s = q_r;
      for (int i = 0; i < WIDTH; i++) begin
         case ({bus.S[i], bus.R[i]})
            2'b00: q_next_s[i] = q_r[i];
            2'b10: q_next_s[i] = 1'b1;
            2'b01: q_next_s[i] = 1'b0;
            2'b11: begin
               // Forbidden combination resolves deterministically, never oscillates
               case (BOTH_POLICY)
                  2'd0:    q_next_s[i] = q_r[i];
                  2'd1:    q_next_s[i] = 1'b1;
                  2'd2:    q_next_s[i] = 1'b0;
                  2'd3:    q_next_s[i] = ~q_r[i];
                  default: q_next_s[i] = q_r[i];
               endcase
            end
            default: q_next_s[i] = q_r[i];
         endcase
      end
   end

   // State and forbidden-input flag registers; reset wins over any request
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r       <= RESET_VAL;
         illegal_r <= {WIDTH{1'b0}};
      end else begin
         q_r       <= q_next_s;
         illegal_r <= bus.S & bus.R;
      end
   end

   assign bus.Q       = q_r;
   assign bus.Q_bar   = ~q_r;
   assign bus.illegal = illegal_r;

endmodule

// File: tb/tb_sr_latch.sv
// Directed bench: five single-bit instances (four S=R=1 policies plus a
// set-on-reset variant) and one 4-bit bank, all checked against hand vectors.
module tb_sr_latch;

   logic       clk;
   logic       rst;
   logic       s1;
   logic       r1;
   logic [3:0] s4;
   logic [3:0] r4;

   int checks;
   int errors;
   int vidx;

   sr_latch_if #(.WIDTH(1)) if_p0 ();
   sr_latch_if #(.WIDTH(1)) if_p1 ();
   sr_latch_if #(.WIDTH(1)) if_p2 ();
   sr_latch_if #(.WIDTH(1)) if_p3 ();
   sr_latch_if #(.WIDTH(1)) if_rv ();
   sr_latch_if #(.WIDTH(4)) if_w4 ();

   assign if_p0.S = s1;  assign if_p0.R = r1;
   assign if_p1.S = s1;  assign if_p1.R = r1;
   assign if_p2.S = s1;  assign if_p2.R = r1;
   assign if_p3.S = s1;  assign if_p3.R = r1;
   assign if_rv.S = s1;  assign if_rv.R = r1;
   assign if_w4.S = s4;  assign if_w4.R = r4;

   sr_latch #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_POLICY(2'd0)) u_p0 (.clk(clk), .rst(rst), .bus(if_p0));
   sr_latch #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_POLICY(2'd1)) u_p1 (.clk(clk), .rst(rst), .bus(if_p1));
   sr_latch #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_POLICY(2'd2)) u_p2 (.clk(clk), .rst(rst), .bus(if_p2));
   sr_latch #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_POLICY(2'd3)) u_p3 (.clk(clk), .rst(rst), .bus(if_p3));
   sr_latch #(.WIDTH(1), .RESET_VAL(1'b1), .BOTH_POLICY(2'd0)) u_rv (.clk(clk), .rst(rst), .bus(if_rv));
   sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(2'd0)) u_w4 (.clk(clk), .rst(rst), .bus(if_w4));

   // Bit order {rv, p3, p2, p1, p0}
   logic [4:0] q_all;
   logic [4:0] qb_all;
   logic [4:0] ill_all;
   assign q_all   = {if_rv.Q, if_p3.Q, if_p2.Q, if_p1.Q, if_p0.Q};
   assign qb_all  = {if_rv.Q_bar, if_p3.Q_bar, if_p2.Q_bar, if_p1.Q_bar, if_p0.Q_bar};
   assign ill_all = {if_rv.illegal, if_p3.illegal, if_p2.illegal, if_p1.illegal, if_p0.illegal};

   typedef struct {
      logic       rst;
      logic       s;
      logic       r;
      logic [4:0] q;
      logic       ill;
      logic [3:0] s4;
      logic [3:0] r4;
      logic [3:0] q4;
      logic [3:0] ill4;
   } vec_t;

   vec_t vecs [16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %b want %b", name, vidx, act, exp);
      end
   endtask

   task automatic check_all(input logic [4:0] q, input logic ill, input logic [3:0] q4, input logic [3:0] ill4);
      check("q1",    {3'b000, q_all},   {3'b000, q});
      check("qbar1", {3'b000, qb_all},  {3'b000, ~q});
      check("ill1",  {3'b000, ill_all}, {3'b000, {5{ill}}});
      check("q4",    {4'b0000, if_w4.Q},       {4'b0000, q4});
      check("qbar4", {4'b0000, if_w4.Q_bar},   {4'b0000, ~q4});
      check("ill4",  {4'b0000, if_w4.illegal}, {4'b0000, ill4});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vidx   = 0;
      //             rst   s     r     q         ill   s4       r4       q4       ill4
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'b10000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'b10000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'b11111, 1'b0, 4'b0011, 4'b0110, 4'b0001, 4'b0010};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 4'b1100, 4'b0001, 4'b1100, 4'b0000};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 4'b1010, 4'b0101, 4'b1010, 4'b0000};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'b01010, 1'b1, 4'b1111, 4'b1111, 4'b1010, 4'b1111};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'b01010, 1'b0, 4'b0000, 4'b0000, 4'b1010, 4'b0000};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'b00010, 1'b1, 4'b0001, 4'b1000, 4'b0011, 4'b0000};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'b01010, 1'b1, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 5'b01010, 1'b0, 4'b0100, 4'b0100, 4'b0011, 4'b0100};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 5'b11111, 1'b0, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 5'b10011, 1'b1, 4'b1000, 4'b0000, 4'b1011, 4'b0000};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 5'b10000, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 5'b11111, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 5'b10000, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000};

      for (int i = 0; i < 16; i++) begin
         rst = vecs[i].rst;
         s1  = vecs[i].s;
         r1  = vecs[i].r;
         s4  = vecs[i].s4;
         r4  = vecs[i].r4;
         @(posedge clk);
         #1;
         vidx = i;
         check_all(vecs[i].q, vecs[i].ill, vecs[i].q4, vecs[i].ill4);
      end

      // Set once, then hold for ten idle edges
      rst = 1'b0; s1 = 1'b1; r1 = 1'b0; s4 = 4'b1111; r4 = 4'b0000;
      @(posedge clk);
      #1;
      vidx = 100;
      check_all(5'b11111, 1'b0, 4'b1111, 4'b0000);
      s1 = 1'b0; s4 = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         vidx = 101 + k;
         check("hold_q1", {3'b000, q_all}, 8'b0001_1111);
         check("hold_q4", {4'b0000, if_w4.Q}, 8'b0000_1111);
      end

      // A clear request between edges must not reach Q before the next edge
      r1 = 1'b1; r4 = 4'b1111;
      #2;
      vidx = 200;
      check("nocomb_q1", {3'b000, q_all}, 8'b0001_1111);
      check("nocomb_q4", {4'b0000, if_w4.Q}, 8'b0000_1111);
      @(posedge clk);
      #1;
      vidx = 201;
      check_all(5'b00000, 1'b0, 4'b0000, 4'b0000);

      // Idle after clear keeps Q low
      r1 = 1'b0; r4 = 4'b0000;
      @(posedge clk);
      #1;
      vidx = 202;
      check_all(5'b00000, 1'b0, 4'b0000, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
